led_band_pingpong_memory: RTL
=============================

LED_BAND_PINGPONG_MEMORY -- requirements
Module: led_band_pingpong_memory

Interface
REQ-001 SHALL have parameter W_ADDR_WIDTH, default 11, write word address width per bank.
REQ-002 SHALL have parameter W_DATA_WIDTH, default 128, write word width.
REQ-003 SHALL have parameter R_DATA_WIDTH, default 8, read word width; W_DATA_WIDTH/R_DATA_WIDTH (RATIO) is a power of two >= 1.
REQ-004 SHALL derive localparam R_ADDR_WIDTH = W_ADDR_WIDTH + log2(RATIO).
REQ-005 clk  in  1  single clock for all ports.
REQ-006 nrst  in  1  asynchronous, active-low reset.
REQ-007 write  in  1  write strobe into back bank.
REQ-008 w_addr  in  W_ADDR_WIDTH  back-bank word address.
REQ-009 w_data  in  W_DATA_WIDTH  write word.
REQ-010 w_done  in  1  one-cycle pulse: back bank frame complete, request swap.
REQ-011 frame_sync  in  1  one-cycle pulse: reader at frame boundary, swap permitted.
REQ-012 read  in  1  read strobe from front bank.
REQ-013 r_addr  in  R_ADDR_WIDTH  front-bank narrow address.
REQ-014 r_data  out  R_DATA_WIDTH  read data.
REQ-015 r_valid  out  1  r_data valid this cycle.
REQ-016 swap_pending  out  1  swap requested, not yet performed; back bank locked.
REQ-017 front_bank  out  1  index of bank currently read.
REQ-018 w_err  out  1  one-cycle pulse: write or w_done rejected.

Function
REQ-019 SHALL hold two banks of 2**W_ADDR_WIDTH words of W_DATA_WIDTH bits each.
REQ-020 Writes SHALL target bank !front_bank; reads SHALL target bank front_bank, both sampled at the same clock edge.
REQ-021 Read mapping: word = r_addr / RATIO, lane = r_addr % RATIO; lane 0 = bits [R_DATA_WIDTH-1:0].
REQ-022 Read latency SHALL be exactly 1 cycle: read at edge N -> r_data, r_valid=1 after edge N; r_valid=0 after any edge without read.
REQ-023 r_data SHALL hold its last value when r_valid=0.
REQ-024 Swap FSM states: IDLE (swap_pending=0), PENDING (swap_pending=1).
REQ-025 IDLE, w_done=1, frame_sync=0 -> PENDING.
REQ-026 IDLE, w_done=1, frame_sync=1 -> front_bank toggles, stay IDLE.
REQ-027 PENDING, frame_sync=1 -> front_bank toggles, -> IDLE.
REQ-028 IDLE, frame_sync without w_done -> no change (front frame is re-displayed).
REQ-029 PENDING, write=1 -> write SHALL be discarded, w_err pulses.
REQ-030 PENDING, w_done=1 -> ignored, w_err pulses; a simultaneous frame_sync still performs the swap.
REQ-031 A read on the swap edge SHALL use the pre-swap front bank; a write on the swap edge (IDLE-direct case, REQ-026) SHALL use the pre-swap back bank.
REQ-032 Simultaneous read and write SHALL never conflict (different banks).
REQ-033 Address wrap: none; all addresses in range by construction.

Reset
REQ-034 nrst low SHALL asynchronously force: state IDLE, front_bank=0, r_valid=0, r_data=0, w_err=0.
REQ-035 Memory contents SHALL NOT be reset; reset mid-operation discards any pending swap.
REQ-036 Outputs SHALL update only on clk edges after nrst deasserts.

Structure
REQ-037 Package led_band_pkg SHALL hold the RATIO/R_ADDR_WIDTH derivation functions and the swap FSM state enum.
REQ-038 One sub-module led_band_bank SHALL implement a single wide-write/narrow-read bank with registered output, instantiated twice.
REQ-039 Banks SHALL infer block RAM; no reset on memory arrays.

Verification
REQ-040 Write word 0 = 0x0F0E..0100 to back bank (bank 1), w_done, frame_sync -> front_bank=1; reads addr 0..15 return 0x00..0x0F, one cycle later, r_valid high.
REQ-041 w_done without frame_sync for 5 cycles -> swap_pending=1, front_bank unchanged; write then -> w_err pulse, memory unchanged; frame_sync -> toggle, swap_pending=0.
REQ-042 w_done and frame_sync same cycle from IDLE -> front_bank toggles next edge, swap_pending stays 0.
REQ-043 Read on swap edge at addr 3 -> r_data from old front bank.
REQ-044 nrst low while PENDING with front_bank=1 -> front_bank=0, swap_pending=0, r_valid=0 immediately, without a clk edge.
REQ-045 Parameter set W_DATA_WIDTH=32, R_DATA_WIDTH=32 (RATIO=1) -> lane select degenerate, REQ-040 equivalent passes.

Source files
------------

// File: rtl/led_band_pkg.sv
// Shared types and width helpers for the LED band ping-pong frame memory.
// Imported by the bank and top modules.
package led_band_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } swap_state_t;

    function automatic int ratio_f(input int w_data, input int r_data);
        return w_data / r_data;
    endfunction

    function automatic int raddr_width_f(input int w_addr, input int w_data,
                                         input int r_data);
        return w_addr + $clog2(w_data / r_data);
    endfunction

endpackage

// File: rtl/led_band_bank.sv
// One frame bank: wide word writes, narrow lane reads, registered output.
// The memory array has no reset so it maps onto block RAM.
module led_band_bank
    import led_band_pkg::*;
#(
    parameter int W_ADDR_WIDTH = 11,
    parameter int W_DATA_WIDTH = 128,
    parameter int R_DATA_WIDTH = 8,
    parameter int R_ADDR_WIDTH = raddr_width_f(W_ADDR_WIDTH, W_DATA_WIDTH,
                                               R_DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    we,
    input  logic [W_ADDR_WIDTH-1:0] w_addr,
    input  logic [W_DATA_WIDTH-1:0] w_data,
    input  logic                    re,
    input  logic [R_ADDR_WIDTH-1:0] r_addr,
    output logic [R_DATA_WIDTH-1:0] r_data
);

    localparam int RATIO   = ratio_f(W_DATA_WIDTH, R_DATA_WIDTH);
    localparam int LANE_W  = $clog2(RATIO);
    localparam int LANE_QW = (LANE_W > 0) ? LANE_W : 1;
    localparam int DEPTH   = 2 ** W_ADDR_WIDTH;

    logic [W_DATA_WIDTH-1:0] mem [DEPTH];
    logic [W_DATA_WIDTH-1:0] word_q;
    logic [W_ADDR_WIDTH-1:0] word_idx;
    logic [LANE_QW-1:0]      lane_d;
    logic [LANE_QW-1:0]      lane_q;
    logic                    loaded_q;
    int                      lane_base;

    assign word_idx  = W_ADDR_WIDTH'(r_addr >> LANE_W);
    assign lane_d    = LANE_QW'(r_addr & R_ADDR_WIDTH'(RATIO - 1));
    assign lane_base = int'(lane_q) * R_DATA_WIDTH;

    // Synchronous RAM port: full-word write, full-word registered read
    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
        if (re) begin
            word_q <= mem[word_idx];
        end
    end

    // Lane index and "has been read" flag travel alongside the RAM output
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lane_q   <= '0;
            loaded_q <= 1'b0;
        end else if (re) begin
            lane_q   <= lane_d;
            loaded_q <= 1'b1;
        end
    end

    // Zero until the first read so the output is clean straight out of reset
    assign r_data = loaded_q ? word_q[lane_base +: R_DATA_WIDTH] : '0;

endmodule

// File: rtl/led_band_pingpong_memory.sv
// Double-buffered LED band frame store: writer fills the back bank,
// reader scans the front bank, banks swap only at a reader frame boundary.
module led_band_pingpong_memory
    import led_band_pkg::*;
#(
    parameter int  W_ADDR_WIDTH = 11,
    parameter int  W_DATA_WIDTH = 128,
    parameter int  R_DATA_WIDTH = 8,
    localparam int R_ADDR_WIDTH = raddr_width_f(W_ADDR_WIDTH, W_DATA_WIDTH,
                                                R_DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    write,
    input  logic [W_ADDR_WIDTH-1:0] w_addr,
    input  logic [W_DATA_WIDTH-1:0] w_data,
    input  logic                    w_done,
    input  logic                    frame_sync,
    input  logic                    read,
    input  logic [R_ADDR_WIDTH-1:0] r_addr,
    output logic [R_DATA_WIDTH-1:0] r_data,
    output logic                    r_valid,
    output logic                    swap_pending,
    output logic                    front_bank,
    output logic                    w_err
);

    swap_state_t             state;
    logic                    wr_ok;
    logic                    rd_sel_q;
    logic [R_DATA_WIDTH-1:0] rd0;
    logic [R_DATA_WIDTH-1:0] rd1;

    // Writes are only accepted while the back bank is unlocked
    assign wr_ok        = write && (state == S_IDLE);
    assign swap_pending = (state == S_PENDING);

    // Swap FSM: bank index and reject pulse are registered with the state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            front_bank <= 1'b0;
            w_err      <= 1'b0;
        end else begin
            w_err <= (state == S_PENDING) && (write || w_done);
            unique case (state)
                S_IDLE: begin
                    if (w_done && frame_sync) begin
                        front_bank <= ~front_bank;
                    end else if (w_done) begin
                        state <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (frame_sync) begin
                        front_bank <= ~front_bank;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Remember which bank produced the last read so r_data holds between reads
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_valid  <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            r_valid <= read;
            if (read) begin
                rd_sel_q <= front_bank;
            end
        end
    end

    led_band_bank #(
        .W_ADDR_WIDTH (W_ADDR_WIDTH),
        .W_DATA_WIDTH (W_DATA_WIDTH),
        .R_DATA_WIDTH (R_DATA_WIDTH),
        .R_ADDR_WIDTH (R_ADDR_WIDTH)
    ) u_bank0 (
        .clk    (clk),
        .nrst   (nrst),
        .we     (wr_ok && front_bank),
        .w_addr (w_addr),
        .w_data (w_data),
        .re     (read && !front_bank),
        .r_addr (r_addr),
        .r_data (rd0)
    );

    led_band_bank #(
        .W_ADDR_WIDTH (W_ADDR_WIDTH),
        .W_DATA_WIDTH (W_DATA_WIDTH),
        .R_DATA_WIDTH (R_DATA_WIDTH),
        .R_ADDR_WIDTH (R_ADDR_WIDTH)
    ) u_bank1 (
        .clk    (clk),
        .nrst   (nrst),
        .we     (wr_ok && !front_bank),
        .w_addr (w_addr),
        .w_data (w_data),
        .re     (read && front_bank),
        .r_addr (r_addr),
        .r_data (rd1)
    );

    assign r_data = rd_sel_q ? rd1 : rd0;

endmodule
